// File: rtl/hazard_control_if.sv
// hazard_control_if: pipeline status inputs and stall/flush/status outputs of the hazard unit
interface hazard_control_if;
  logic [1:0] ID_RS;
  logic [1:0] ID_RT;
  logic ID_Use_RS;
  logic ID_Use_RT;
  logic ID_Jump;
  logic EX_Mem_Read;
  logic [1:0] EX_RD;
  logic EX_Branch_Taken;
  logic EX_JRL;
  logic MEM_Busy;
  logic WB_Valid;
  logic WB_Halt;
  logic PC_Write;
  logic IFID_Write;
  logic IDEX_Write;
  logic EXMEM_Write;
  logic MEMWB_Write;
  logic IFID_Flush;
  logic IDEX_Flush;
  logic Halted;
  logic Error;
  logic [15:0] Stall_Count;
  logic [15:0] Retired_Count;
  modport master (
    output ID_RS, ID_RT, ID_Use_RS, ID_Use_RT, ID_Jump, EX_Mem_Read, EX_RD,
           EX_Branch_Taken, EX_JRL, MEM_Busy, WB_Valid, WB_Halt,
    input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
           IFID_Flush, IDEX_Flush, Halted, Error, Stall_Count, Retired_Count
  );
  modport slave (
    input  ID_RS, ID_RT, ID_Use_RS, ID_Use_RT, ID_Jump, EX_Mem_Read, EX_RD,
           EX_Branch_Taken, EX_JRL, MEM_Busy, WB_Valid, WB_Halt,
    output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
           IFID_Flush, IDEX_Flush, Halted, Error, Stall_Count, Retired_Count
  );
endinterface

// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush control with memory-wait timeout, halt and perf counters
module hazard_control #(
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic reset_n,
  hazard_control_if.slave hc
);
  localparam int W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
  state_t state, state_n;
  logic [W-1:0] wait_cnt, cnt_n;
  logic halted, halted_n, error, error_n;
  logic [15:0] stall_cnt, stall_n, retired_cnt, retired_n;
  logic load_use, redirect, freeze, active;
  logic [6:0] ctl;
  assign load_use = hc.EX_Mem_Read && ((hc.ID_Use_RS && hc.EX_RD == hc.ID_RS) ||
                                       (hc.ID_Use_RT && hc.EX_RD == hc.ID_RT));
  assign redirect = hc.EX_Branch_Taken || hc.EX_JRL;
  assign active = state != HALT;
  assign freeze = active && hc.MEM_Busy;
  // {PC, IFID, IDEX, EXMEM, MEMWB writes, IFID flush, IDEX flush}
  always_comb
    ctl = !reset_n       ? 7'b0000011 :
          !active        ? 7'b0000000 :
          freeze         ? 7'b0000000 :
          redirect       ? 7'b1111111 :
          load_use       ? 7'b0011101 :
          hc.ID_Jump     ? 7'b1111110 :
                           7'b1111100;
  assign {hc.PC_Write, hc.IFID_Write, hc.IDEX_Write, hc.EXMEM_Write, hc.MEMWB_Write,
          hc.IFID_Flush, hc.IDEX_Flush} = ctl;
  always_comb begin
    state_n = state;
    cnt_n = wait_cnt;
    halted_n = halted;
    error_n = error;
    if (active) begin
      if (hc.MEM_Busy) begin
        if (state == RUN) begin
          state_n = WAIT;
          cnt_n = W'(1);
        end else if (wait_cnt < W'(MAX_WAIT)) begin
          cnt_n = wait_cnt + W'(1);
        end else begin
          state_n = HALT;
          error_n = 1'b1;
        end
      end else begin
        state_n = RUN;
        cnt_n = '0;
        if (hc.WB_Valid && hc.WB_Halt) begin
          state_n = HALT;
          halted_n = 1'b1;
        end
      end
    end
  end
  // counters saturate rather than wrap; nothing counts once halted
  always_comb begin
    stall_n = (active && !ctl[6] && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    retired_n = (active && !hc.MEM_Busy && hc.WB_Valid && retired_cnt != 16'hFFFF)
              ? retired_cnt + 16'd1 : retired_cnt;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      wait_cnt <= '0;
      halted <= 1'b0;
      error <= 1'b0;
      stall_cnt <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= cnt_n;
      halted <= halted_n;
      error <= error_n;
      stall_cnt <= stall_n;
      retired_cnt <= retired_n;
    end
  end
  assign hc.Halted = halted;
  assign hc.Error = error;
  assign hc.Stall_Count = stall_cnt;
  assign hc.Retired_Count = retired_cnt;
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scoreboard bench for hazard_control
module tb_hazard_control;
  logic clk = 1'b0;
  logic reset_n;
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] ctl_q[$];
  logic [33:0] reg_q[$];
  hazard_control_if hc();
  hazard_control #(.MAX_WAIT(15)) dut (.clk(clk), .reset_n(reset_n), .hc(hc));
  always #5 clk = ~clk;
  localparam logic [6:0] C_RST = 7'b0000011, C_OFF = 7'b0000000, C_RED = 7'b1111111,
                         C_LU = 7'b0011101, C_JMP = 7'b1111110, C_NRM = 7'b1111100;
  function automatic logic [33:0] r(input logic h, input logic e, input int s, input int rt);
    return {h, e, 16'(s), 16'(rt)};
  endfunction
  task automatic idle();
    hc.ID_RS = 2'd0;
    hc.ID_RT = 2'd0;
    hc.ID_Use_RS = 1'b0;
    hc.ID_Use_RT = 1'b0;
    hc.ID_Jump = 1'b0;
    hc.EX_Mem_Read = 1'b0;
    hc.EX_RD = 2'd0;
    hc.EX_Branch_Taken = 1'b0;
    hc.EX_JRL = 1'b0;
    hc.MEM_Busy = 1'b0;
    hc.WB_Valid = 1'b0;
    hc.WB_Halt = 1'b0;
  endtask
  task automatic lu_hit();
    hc.EX_Mem_Read = 1'b1;
    hc.EX_RD = 2'd2;
    hc.ID_RS = 2'd2;
    hc.ID_Use_RS = 1'b1;
  endtask
  // called at a falling edge with inputs set; checks comb outputs, then registers after the edge
  task automatic cyc(input string tag, input logic [6:0] ec, input logic [33:0] er);
    logic [6:0] oc, xc;
    logic [33:0] orr, xr;
    ctl_q.push_back(ec);
    reg_q.push_back(er);
    #1;
    oc = {hc.PC_Write, hc.IFID_Write, hc.IDEX_Write, hc.EXMEM_Write, hc.MEMWB_Write,
          hc.IFID_Flush, hc.IDEX_Flush};
    xc = ctl_q.pop_front();
    n_chk++;
    assert (oc === xc) else begin
      n_fail++;
      $error("FAIL %s ctl got %b want %b", tag, oc, xc);
    end
    @(posedge clk);
    #1;
    orr = {hc.Halted, hc.Error, hc.Stall_Count, hc.Retired_Count};
    xr = reg_q.pop_front();
    n_chk++;
    assert (orr === xr) else begin
      n_fail++;
      $error("FAIL %s regs{halt,err,stall,ret} got %h want %h", tag, orr, xr);
    end
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    cyc("reset", C_RST, r(0, 0, 0, 0));
    reset_n = 1'b1;
    cyc("normal", C_NRM, r(0, 0, 0, 0));
    hc.ID_Jump = 1'b1;
    cyc("jump", C_JMP, r(0, 0, 0, 0));
    idle();
    lu_hit();
    cyc("load_use_rs", C_LU, r(0, 0, 1, 0));
    hc.ID_Use_RS = 1'b0;
    hc.ID_RS = 2'd1;
    hc.ID_RT = 2'd2;
    hc.ID_Use_RT = 1'b1;
    cyc("load_use_rt", C_LU, r(0, 0, 2, 0));
    hc.EX_RD = 2'd3;
    cyc("lu_miss_rd", C_NRM, r(0, 0, 2, 0));
    hc.EX_RD = 2'd2;
    hc.ID_RS = 2'd2;
    hc.ID_Use_RT = 1'b0;
    cyc("lu_miss_use", C_NRM, r(0, 0, 2, 0));
    hc.ID_Use_RS = 1'b1;
    hc.EX_Mem_Read = 1'b0;
    cyc("lu_miss_noload", C_NRM, r(0, 0, 2, 0));
    idle();
    lu_hit();
    hc.EX_Branch_Taken = 1'b1;
    cyc("redirect_over_lu", C_RED, r(0, 0, 2, 0));
    idle();
    hc.EX_JRL = 1'b1;
    hc.ID_Jump = 1'b1;
    cyc("jrl_over_jump", C_RED, r(0, 0, 2, 0));
    idle();
    hc.EX_JRL = 1'b1;
    hc.MEM_Busy = 1'b1;
    hc.WB_Valid = 1'b1;
    for (int i = 1; i <= 3; i++) cyc($sformatf("freeze%0d", i), C_OFF, r(0, 0, 2 + i, 0));
    hc.MEM_Busy = 1'b0;
    hc.WB_Valid = 1'b0;
    cyc("freeze_release_redirect", C_RED, r(0, 0, 5, 0));
    idle();
    hc.WB_Valid = 1'b1;
    for (int i = 1; i <= 4; i++) cyc($sformatf("retire%0d", i), C_NRM, r(0, 0, 5, i));
    hc.WB_Halt = 1'b1;
    hc.MEM_Busy = 1'b1;
    cyc("frozen_hlt", C_OFF, r(0, 0, 6, 4));
    hc.MEM_Busy = 1'b0;
    cyc("hlt", C_NRM, r(1, 0, 6, 5));
    hc.WB_Halt = 1'b0;
    lu_hit();
    cyc("halted_wb", C_OFF, r(1, 0, 6, 5));
    hc.MEM_Busy = 1'b1;
    cyc("halted_busy", C_OFF, r(1, 0, 6, 5));
    idle();
    reset_n = 1'b0;
    cyc("reset_in_halt", C_RST, r(0, 0, 0, 0));
    reset_n = 1'b1;
    cyc("after_reset", C_NRM, r(0, 0, 0, 0));
    hc.MEM_Busy = 1'b1;
    for (int i = 1; i <= 16; i++) cyc($sformatf("wait%0d", i), C_OFF, r(0, i == 16, i, 0));
    idle();
    hc.EX_Branch_Taken = 1'b1;
    cyc("timeout_halt", C_OFF, r(0, 1, 16, 0));
    hc.WB_Valid = 1'b1;
    hc.WB_Halt = 1'b1;
    cyc("timeout_halt_hlt", C_OFF, r(0, 1, 16, 0));
    idle();
    reset_n = 1'b0;
    cyc("reset2", C_RST, r(0, 0, 0, 0));
    reset_n = 1'b1;
    hc.MEM_Busy = 1'b1;
    cyc("busy_a", C_OFF, r(0, 0, 1, 0));
    cyc("busy_b", C_OFF, r(0, 0, 2, 0));
    reset_n = 1'b0;
    cyc("reset_in_wait", C_RST, r(0, 0, 0, 0));
    reset_n = 1'b1;
    hc.MEM_Busy = 1'b0;
    cyc("after_wait_reset", C_NRM, r(0, 0, 0, 0));
    lu_hit();
    hc.WB_Valid = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    cyc("saturate", C_LU, r(0, 0, 65535, 65535));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: the maximum number of consecutive MEM_Busy cycles tolerated before the error halt.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset that is synchronous and active-low.
REQ-004 SHALL have ports ID_RS and ID_RT, input, 2 bits each: the source registers of the instruction in ID.
REQ-005 SHALL have ports ID_Use_RS and ID_Use_RT, input, 1 bit each: the ID instruction actually reads RS/RT.
REQ-006 SHALL have port ID_Jump, input, 1 bit: a direct jump (JMP/JAL) is decoded in ID.
REQ-007 SHALL have ports EX_Mem_Read, input, 1 bit, and EX_RD, input, 2 bits: a load is in EX, and its destination register.
REQ-008 SHALL have ports EX_Branch_Taken and EX_JRL, input, 1 bit each: a taken branch or a JRL is resolved in EX.
REQ-009 SHALL have port MEM_Busy, input, 1 bit: data memory is not ready this cycle.
REQ-010 SHALL have ports WB_Valid and WB_Halt, input, 1 bit each: an instruction is in WB, and that instruction is HLT.
REQ-011 SHALL have outputs PC_Write, IFID_Write, IDEX_Write, EXMEM_Write and MEMWB_Write, 1 bit each: the pipeline-register write enables.
REQ-012 SHALL have outputs IFID_Flush and IDEX_Flush, 1 bit each: insert a bubble into the named register.
REQ-013 SHALL have outputs Halted and Error, 1 bit each, registered: halt status and timeout status.
REQ-014 SHALL have outputs Stall_Count and Retired_Count, 16 bits each, registered: performance counters.

Function
REQ-015 SHALL implement states RUN, WAIT and HALT, and SHALL compute all enable and flush outputs combinationally from the state and the current inputs.
REQ-016 SHALL define load_use as EX_Mem_Read && ((ID_Use_RS && EX_RD==ID_RS) || (ID_Use_RT && EX_RD==ID_RT)).
REQ-017 SHALL apply this output priority, highest first: reset, HALT, freeze, redirect, load_use, jump, normal.
REQ-018 SHALL, in state HALT, drive all *_Write signals to 0 and both flushes to 0.
REQ-019 SHALL treat any cycle with MEM_Busy=1 in RUN or WAIT as a freeze: all *_Write signals 0, both flushes 0.
REQ-020 SHALL, when unfrozen and EX_Branch_Taken or EX_JRL is 1, make a redirect: PC_Write=1, IFID_Flush=1, IDEX_Flush=1, all other writes 1.
REQ-021 SHALL, when unfrozen with no redirect and load_use is 1, drive PC_Write=0, IFID_Write=0 and IDEX_Flush=1, with all other writes 1.
REQ-022 SHALL, when unfrozen with no redirect, no load_use and ID_Jump=1, drive IFID_Flush=1 with all writes 1.
REQ-023 SHALL, in the normal case, drive all writes to 1 and both flushes to 0.
REQ-024 SHALL ignore a redirect asserted during a freeze; it takes effect on the first unfrozen cycle, because the EX inputs are held by the freeze.
REQ-025 SHALL use an internal wait counter, wait_cnt (4 bits minimum).
REQ-026 SHALL, in RUN with MEM_Busy=1, go to WAIT with wait_cnt=1.
REQ-027 SHALL, in WAIT with MEM_Busy=1 and wait_cnt<MAX_WAIT, increment wait_cnt.
REQ-028 SHALL, in WAIT with MEM_Busy=1 and wait_cnt==MAX_WAIT, go to HALT and set Error=1.
REQ-029 SHALL, in WAIT with MEM_Busy=0, go to RUN, clear wait_cnt and apply the RUN output rules that same cycle.
REQ-030 SHALL go to HALT and set Halted=1 on the next edge when WB_Valid && WB_Halt in an unfrozen cycle; a frozen HLT SHALL NOT halt.
REQ-031 SHALL make HALT sticky until reset: Halted remains 1 there, and Error is set only by timeout.
REQ-032 SHALL increment Retired_Count when WB_Valid=1 in an unfrozen RUN/WAIT cycle, including the HLT cycle.
REQ-033 SHALL increment Stall_Count in each RUN/WAIT cycle where PC_Write=0; freeze and load_use cycles count, redirect cycles do not.
REQ-034 SHALL saturate both counters at 16'hFFFF with no wrap-around.

Reset
REQ-035 SHALL, on a clock edge with reset_n=0, set state RUN, wait_cnt=0, Halted=0, Error=0 and both counters to 0.
REQ-036 SHALL, while reset_n=0, drive all *_Write signals to 0 and both flushes to 1.
REQ-037 SHALL allow reset to abort WAIT or HALT in any cycle, with the first cycle after release behaving as RUN.

Verification
REQ-038 SHALL cover load-use: EX_Mem_Read=1, EX_RD=2, ID_RS=2, ID_Use_RS=1 for 1 cycle -> PC_Write=0, IFID_Write=0, IDEX_Flush=1, Stall_Count=1.
REQ-039 SHALL cover redirect over load-use: EX_Branch_Taken=1 together with a load_use hit -> PC_Write=1, IFID_Flush=1, IDEX_Flush=1, Stall_Count unchanged.
REQ-040 SHALL cover freeze with redirect: MEM_Busy=1 for 3 cycles with EX_JRL=1 held -> 3 cycles of all writes 0 and Stall_Count=3, then the redirect on cycle 4 with state RUN.
REQ-041 SHALL cover timeout: MAX_WAIT=15 with MEM_Busy held for 16 cycles -> HALT after the 16th edge, Error=1, Halted=0, all writes 0 thereafter.
REQ-042 SHALL cover halt: 5 WB_Valid retirements, the 5th with WB_Halt=1 -> Retired_Count=5, Halted=1 next cycle, counters frozen; a later WB_Valid=1 leaves Retired_Count=5.
REQ-043 SHALL cover reset: reset_n=0 for 1 edge while in HALT -> Halted=0, counters 0, writes=0 and flushes=1 during reset; first cycle after release gives normal outputs.
